// File: rtl/data_ram_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_pkg
// Shared types and constants for the data-memory responder:
//   - WORD_W                    : data word width (32)
//   - LATENCY_MIN/LATENCY_MAX   : legal read-latency range
//   - fault_e                   : reason an access was rejected
//   - resp_t                    : one response slot {valid, fault, data}
//   - classify_access()         : alignment / range check of a byte address
//   - sat_inc()                 : saturating 32-bit increment (statistics)
// -----------------------------------------------------------------------------
package data_ram_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FAULT_NONE         = 2'd0,
    FAULT_MISALIGNED   = 2'd1,
    FAULT_OUT_OF_RANGE = 2'd2
  } fault_e;

  typedef struct packed {
    logic  valid;
    logic  fault;
    word_t data;
  } resp_t;

  // The offset is computed one bit wider than the address so that an address
  // below the base shows up as a borrow in bit 32 instead of wrapping around
  // into the legal window.
  function automatic fault_e classify_access(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input int unsigned depth_words);
    logic [32:0] offset;
    logic [32:0] span;
    offset = {1'b0, addr} - {1'b0, base};
    span   = 33'(depth_words) << 2;
    if (addr[1:0] != 2'b00) return FAULT_MISALIGNED;
    if (offset[32] || (offset >= span)) return FAULT_OUT_OF_RANGE;
    return FAULT_NONE;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// -----------------------------------------------------------------------------
// data_ram_if
// Load/store port between the core (master) and the data RAM (slave).
//   d_address      master->slave  byte address, one access every cycle
//   d_data_write   master->slave  store data
//   d_write_enable master->slave  1 = store, 0 = load
//   d_data_read    slave->master  load data, qualified by d_data_valid
//   d_data_valid   slave->master  one-cycle response qualifier
//   err            slave->master  pulses with the response slot of a fault
//   err_sticky     slave->master  set by any fault, cleared only by reset
// -----------------------------------------------------------------------------
interface data_ram_if;
  import data_ram_pkg::*;

  logic [31:0] d_address;
  word_t       d_data_write;
  logic        d_write_enable;
  word_t       d_data_read;
  logic        d_data_valid;
  logic        err;
  logic        err_sticky;

  modport master (
    output d_address, d_data_write, d_write_enable,
    input  d_data_read, d_data_valid, err, err_sticky
  );

  modport slave (
    input  d_address, d_data_write, d_write_enable,
    output d_data_read, d_data_valid, err, err_sticky
  );
endinterface

// File: rtl/ram_resp_pipe.sv
// -----------------------------------------------------------------------------
// ram_resp_pipe
// STAGES-deep shift register of response slots with asynchronous reset.
// STAGES = 0 is a pure pass-through.
//   clk     clock, rising edge
//   reset   asynchronous active-high reset, empties every stage
//   resp_i  response entering the pipe
//   resp_o  response leaving the pipe STAGES cycles later
// -----------------------------------------------------------------------------
module ram_resp_pipe
  import data_ram_pkg::*;
#(
  parameter int unsigned STAGES = 0
) (
  input  logic  clk,
  input  logic  reset,
  input  resp_t resp_i,
  output resp_t resp_o
);

  if (STAGES == 0) begin : g_bypass
    // Clock and reset are not needed in the bypass build.
    logic unused_bypass;
    assign unused_bypass = clk ^ reset;
    assign resp_o = resp_i;
  end else begin : g_pipe
    resp_t stage_q [STAGES];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's old value at the same edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= resp_i;
        for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign resp_o = stage_q[STAGES-1];
  end

endmodule

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram
// Word-organised synchronous data RAM answering the core's load/store port.
// Every cycle is one access (store when d_write_enable=1, else load). Loads
// respond LATENCY cycles later with d_data_valid; faulting accesses
// (misaligned or outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)) pulse err in
// their response slot and never touch the array; faulting loads return 0.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words, power of two
//   BASE_ADDR    byte address of word 0, aligned to DEPTH_WORDS*4
//   LATENCY      read latency in cycles, 1..4
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   bus          data_ram_if.slave load/store port
//   load_count   (DATA_RAM_STATS_EN only) saturating count of loads
//   store_count  (DATA_RAM_STATS_EN only) saturating count of stores
//   fault_count  (DATA_RAM_STATS_EN only) saturating count of faults
// Optional feature macro: DATA_RAM_STATS_EN
// -----------------------------------------------------------------------------
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic       clk,
  input  logic       reset,
  data_ram_if.slave  bus
`ifdef DATA_RAM_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] fault_count
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
    $error("data_ram: LATENCY must be within 1..4");
  end
  if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
    $error("data_ram: DEPTH_WORDS must be a power of two >= 2");
  end
  if ((BASE_ADDR & 32'((DEPTH_WORDS * 4) - 1)) != 32'd0) begin : g_bad_base
    $error("data_ram: BASE_ADDR must be aligned to DEPTH_WORDS*4");
  end

  fault_e           fault_reason;
  logic             fault;
  logic [IDX_W-1:0] word_idx;
  word_t            mem_q [DEPTH_WORDS];
  resp_t            rd_d;
  resp_t            rd_q;
  resp_t            resp_out;
  logic             err_sticky_q;

  assign fault_reason = classify_access(bus.d_address, BASE_ADDR, DEPTH_WORDS);
  assign fault        = (fault_reason != FAULT_NONE);
  // Only meaningful when the access is in range; faults never use it.
  assign word_idx     = IDX_W'((bus.d_address - BASE_ADDR) >> 2);

  // NOTE: the array itself has no reset so it maps onto block RAM; a store
  // presented while reset is high is simply not committed.
  always_ff @(posedge clk) begin
    if (!reset && bus.d_write_enable && !fault) begin
      mem_q[word_idx] <= bus.d_data_write;
    end
  end

  // First response stage. A store occupies its slot with valid=0 so that a
  // faulting store still reports err exactly LATENCY cycles later.
  // NOTE: the whole struct gets a default first so no path leaves a field
  // unassigned and infers a latch.
  always_comb begin
    rd_d       = '0;
    rd_d.valid = !bus.d_write_enable;
    rd_d.fault = fault;
    if (!bus.d_write_enable && !fault) rd_d.data = mem_q[word_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  ram_resp_pipe #(
    .STAGES (LATENCY - 1)
  ) u_resp_pipe (
    .clk    (clk),
    .reset  (reset),
    .resp_i (rd_q),
    .resp_o (resp_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_sticky_q <= 1'b0;
    else       err_sticky_q <= err_sticky_q | resp_out.fault;
  end

  assign bus.d_data_read  = resp_out.data;
  assign bus.d_data_valid = resp_out.valid;
  assign bus.err          = resp_out.fault;
  // Sticky flag rises in the same cycle as the err pulse that causes it.
  assign bus.err_sticky   = err_sticky_q | resp_out.fault;

`ifdef DATA_RAM_STATS_EN
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;
  logic [31:0] fault_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      fault_cnt_q <= '0;
    end else begin
      if (bus.d_write_enable) store_cnt_q <= sat_inc(store_cnt_q);
      else                    load_cnt_q  <= sat_inc(load_cnt_q);
      if (fault)              fault_cnt_q <= sat_inc(fault_cnt_q);
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
  assign fault_count = fault_cnt_q;
`endif

endmodule

// File: tb/tb_data_ram.sv
// -----------------------------------------------------------------------------
// tb_data_ram
// Three data_ram instances share one stimulus stream:
//   u_l1 : LATENCY=1, BASE 0
//   u_l3 : LATENCY=3, BASE 0
//   u_l4 : LATENCY=4, BASE 32'h2000 (exercises addresses below the base)
// A table of {access, expected result for BASE 0} drives the main checks; the
// BASE 0x2000 instance uses a small reference memory. Every access pushes a
// scoreboard entry tagged with the cycle its response is due; every cycle the
// outputs are compared with the due entry, or with an idle slot otherwise.
// -----------------------------------------------------------------------------
module tb_data_ram;
  import data_ram_pkg::*;

  localparam int          NDUT  = 3;
  localparam logic [31:0] BASE4 = 32'h0000_2000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          due;
    logic        valid;
    logic        err;
    logic        known;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_ram_if if1 ();
  data_ram_if if3 ();
  data_ram_if if4 ();

`ifdef DATA_RAM_STATS_EN
  logic [31:0] lc [NDUT];
  logic [31:0] sc [NDUT];
  logic [31:0] fc [NDUT];
`endif

  data_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .bus(if1)
`ifdef DATA_RAM_STATS_EN
    , .load_count(lc[0]), .store_count(sc[0]), .fault_count(fc[0])
`endif
  );

  data_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .bus(if3)
`ifdef DATA_RAM_STATS_EN
    , .load_count(lc[1]), .store_count(sc[1]), .fault_count(fc[1])
`endif
  );

  data_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE4), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .bus(if4)
`ifdef DATA_RAM_STATS_EN
    , .load_count(lc[2]), .store_count(sc[2]), .fault_count(fc[2])
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  sb_t         sbq [NDUT][$];
  logic        sticky_m [NDUT];
  logic [31:0] mem4 [int unsigned];
  int unsigned n_ld = 0;
  int unsigned n_st = 0;
  int unsigned n_flt = 0;
  vec_t        tbl [25];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic exp_err,
                              input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if1.d_write_enable = we; if1.d_address = addr; if1.d_data_write = wdata;
    if3.d_write_enable = we; if3.d_address = addr; if3.d_data_write = wdata;
    if4.d_write_enable = we; if4.d_address = addr; if4.d_data_write = wdata;
  endtask

  // Compare every instance against its due scoreboard entry (idle if none).
  task automatic check_outputs();
    for (int k = 0; k < NDUT; k++) begin
      logic        v, e, s;
      logic [31:0] d;
      sb_t         exp;
      string       tag;
      case (k)
        0:       begin v = if1.d_data_valid; e = if1.err; s = if1.err_sticky; d = if1.d_data_read; end
        1:       begin v = if3.d_data_valid; e = if3.err; s = if3.err_sticky; d = if3.d_data_read; end
        default: begin v = if4.d_data_valid; e = if4.err; s = if4.err_sticky; d = if4.d_data_read; end
      endcase
      exp = '{due: cyc, valid: 1'b0, err: 1'b0, known: 1'b1, data: 32'h0};
      if (sbq[k].size() != 0 && sbq[k][0].due == cyc) exp = sbq[k].pop_front();
      sticky_m[k] = sticky_m[k] | exp.err;
      tag = $sformatf("lat%0d", lat_of(k));
      check({tag, "_valid"},      32'(v), 32'(exp.valid));
      check({tag, "_err"},        32'(e), 32'(exp.err));
      check({tag, "_err_sticky"}, 32'(s), 32'(sticky_m[k]));
      if ((exp.valid && exp.known) || reset) check({tag, "_rdata"}, d, exp.data);
    end
  endtask

  // One access cycle with reset low: drive, record expectations, check the
  // outputs of this cycle, then advance to just after the accepting edge.
  task automatic step(input vec_t v);
    logic        f4;
    int unsigned idx4;
    sb_t         e4;
    drive(v.we, v.addr, v.wdata);
    for (int k = 0; k < 2; k++) begin
      sbq[k].push_back('{due: cyc + lat_of(k), valid: !v.we, err: v.exp_err,
                         known: 1'b1, data: (v.we ? 32'h0 : v.exp_rdata)});
    end
    f4   = (v.addr[1:0] != 2'b00) || (v.addr < BASE4) || (v.addr >= BASE4 + 32'h1000);
    idx4 = (v.addr - BASE4) >> 2;
    e4   = '{due: cyc + lat_of(2), valid: !v.we, err: f4, known: 1'b1, data: 32'h0};
    if (v.we) begin
      if (!f4) mem4[idx4] = v.wdata;
    end else if (!f4) begin
      if (mem4.exists(idx4)) e4.data = mem4[idx4];
      else                   e4.known = 1'b0;
    end
    sbq[2].push_back(e4);
    if (v.we) n_st++; else n_ld++;
    if (v.exp_err) n_flt++;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
    tbl[2]  = mk(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 32'h0000_0004, 32'h0000_0002, 1'b0, 32'h0);
    tbl[4]  = mk(1'b1, 32'h0000_0008, 32'h0000_0003, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0001);
    tbl[6]  = mk(1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0000_0002);
    tbl[7]  = mk(1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0003);
    tbl[8]  = mk(1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0);
    tbl[9]  = mk(1'b1, 32'h0000_0013, 32'h1234_5678, 1'b1, 32'h0);
    tbl[10] = mk(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
    tbl[11] = mk(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0);
    tbl[12] = mk(1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D);
    tbl[13] = mk(1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0);
    tbl[14] = mk(1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 1'b1, 32'h0);
    tbl[15] = mk(1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0001);
    tbl[16] = mk(1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 1'b1, 32'h0);
    tbl[17] = mk(1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0);
    tbl[18] = mk(1'b1, 32'h0000_2FFC, 32'h5A5A_5A5A, 1'b1, 32'h0);
    tbl[19] = mk(1'b0, 32'h0000_2FFC, 32'h0,         1'b1, 32'h0);
    tbl[20] = mk(1'b0, 32'h0000_3000, 32'h0,         1'b1, 32'h0);
    tbl[21] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0);
    tbl[22] = mk(1'b1, 32'h0000_0010, 32'h0F0F_0F0F, 1'b0, 32'h0);
    tbl[23] = mk(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h0F0F_0F0F);
    tbl[24] = mk(1'b0, 32'h0000_0002, 32'h0,         1'b1, 32'h0);

    for (int k = 0; k < NDUT; k++) sticky_m[k] = 1'b0;

    // Reset state: all outputs low while reset is held.
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // First access lands in the first cycle after reset deasserts.
    for (int i = 0; i < 25; i++) step(tbl[i]);
    repeat (5) step(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0001));

`ifdef DATA_RAM_STATS_EN
    check("load_count",  lc[0], n_ld);
    check("store_count", sc[0], n_st);
    check("fault_count", fc[0], n_flt);
`endif

    // Mid-flight reset: two loads issued, reset pulsed for one cycle two
    // cycles after the first; a store presented during reset must not land.
    step(mk(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0F0F_0F0F));
    step(mk(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0F0F_0F0F));
    reset = 1'b1;
    drive(1'b1, 32'h0000_0010, 32'h7777_7777);
    for (int k = 0; k < NDUT; k++) begin
      sbq[k].delete();
      sticky_m[k] = 1'b0;
    end
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;

`ifdef DATA_RAM_STATS_EN
    n_ld = 0; n_st = 0; n_flt = 0;
`endif

    step(mk(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0F0F_0F0F));
    repeat (6) step(mk(1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0001));

`ifdef DATA_RAM_STATS_EN
    check("load_count_after_reset",  lc[0], n_ld);
    check("store_count_after_reset", sc[0], n_st);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_ram.md
# data_ram

Data-memory responder on the core's load/store port: answers the `d_address` / `d_data_write` / `d_write_enable` requests driven by the pipelined RISC-V core and returns `d_data_read` / `d_data_valid`. It is a word-organised synchronous RAM with a configurable read-latency pipeline, alignment and range checking, and an optional access-statistics block. It sits beside the instruction ROM in the simulation and FPGA top level.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- `LATENCY`, default 1: read latency in cycles, legal range 1..4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `d_address`  in  32  byte address from the core; sampled every cycle.
- `d_data_write`  in  32  store data.
- `d_write_enable`  in  1  1 = store this cycle, 0 = load this cycle.
- `d_data_read`  out  32  load data, meaningful only when `d_data_valid`=1.
- `d_data_valid`  out  1  1-cycle-per-response qualifier for `d_data_read`.
- `err`  out  1  pulses with the response of a faulting access.
- `err_sticky`  out  1  set by any fault, cleared only by reset.

## Operation
- Every cycle is one access: store if `d_write_enable`=1, else load. There is no idle encoding; the core drives an address every cycle.
- Word index = (d_address − BASE_ADDR) >> 2, width $clog2(DEPTH_WORDS).
- Fault conditions: `d_address[1:0]` ≠ 0 (misaligned), or address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS). Faulting store: array untouched. Faulting load: returns 32'h0.
- Store: full word written at the rising edge ending the store cycle. Stores produce no read response; `d_data_valid` stays 0 for their slot; a faulting store still pulses `err`, aligned to slot LATENCY.
- Load: array read at the edge ending the load cycle, then delayed through LATENCY−1 further registers together with its valid and fault bits.
- Load immediately after a store to the same word returns the new data (store committed one edge earlier). No forwarding logic is needed.
- Array contents are not reset; the response pipeline, `err`, and `err_sticky` are.
- `err_sticky` sets in the same cycle `err` is 1.

## Timing
- Load presented in cycle T → `d_data_read`/`d_data_valid` in cycle T+LATENCY, held for exactly one cycle.
- Back-to-back loads: one response per cycle; throughput 1 access/cycle, no stalls, no back-pressure.
- Reset values: `d_data_read`=0, `d_data_valid`=0, `err`=0, `err_sticky`=0, all pipeline stages invalid.
- Reset asserted mid-operation: all in-flight responses dropped immediately (asynchronously); no stale `d_data_valid` after deassertion; a store in the cycle reset is asserted is not committed.
- First access is accepted in the first cycle after reset deasserts.
- Address wrap: BASE_ADDR + 4*DEPTH_WORDS − 4 is the last legal word; the next word faults. An address below BASE_ADDR faults; no modulo aliasing.

## Configuration
- `DATA_RAM_STATS_EN` defined: adds 32-bit saturating counters `load_count`, `store_count`, and `fault_count`, exposed as extra output ports. Counters clear on reset, increment on the accepting edge of each access, and saturate at 32'hFFFF_FFFF without wrapping.
- Macro undefined: counters and their ports are absent; behaviour is otherwise identical.

## Structure
- `data_ram_pkg`: word width constant (32), LATENCY min/max constants, fault-reason enum (NONE, MISALIGNED, OUT_OF_RANGE), and a response struct {valid, fault, data}.
- Sub-module `ram_resp_pipe`: parameterised LATENCY−1 stage shift register of the response struct with async reset. For LATENCY=1 it is a pass-through.

## Test plan
- LATENCY=1: store 32'hDEADBEEF at 0x10, load 0x10 next cycle → `d_data_valid`=1 with 32'hDEADBEEF exactly 1 cycle after the load, `err`=0.
- LATENCY=3: loads of 0x0, 0x4, 0x8 on consecutive cycles (preloaded 1, 2, 3) → responses 1, 2, 3 in cycles T+3, T+4, T+5, with `d_data_valid` high for exactly those 3 cycles.
- Load 0x13 → data 0, `err` pulse at T+LATENCY, `err_sticky`=1 thereafter. Store to 0x13 → array at 0x10 unchanged.
- DEPTH_WORDS=1024, BASE 0: load 0xFFC → valid data, no error. Load 0x1000 → data 0 with error. Store 0x1000 → word 0 unchanged, no aliasing.
- LATENCY=4: issue a load, assert reset 2 cycles later for 1 cycle → no `d_data_valid` ever appears for that load; outputs read 0 during reset. `err_sticky` is cleared.
- With `DATA_RAM_STATS_EN`: 5 loads, 3 stores, 1 misaligned load → `load_count`=6, `store_count`=3, `fault_count`=1.
